// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen
//
// Debounces a raw push-button and emits a single-cycle toggle strobe for a
// downstream T flip-flop once per accepted press.
//
// The raw level is synchronised into the clock domain. A free-running
// prescaler produces a slow enable tick. A four-state debounce FSM accepts a
// level change only after DEB_TICKS consecutive ticks with the new level held.
// Any bounce restarts the count.
//
// Parameters
//   DIV        clk cycles per enable tick (>= 2)
//   DEB_TICKS  consecutive stable ticks needed to accept a change (>= 1)
//
// Ports
//   clk    in   system clock; all state changes on its rising edge
//   reset  in   asynchronous, active-low reset
//   btn    in   raw, bouncy, asynchronous button level
//   t      out  one-cycle toggle strobe per accepted press (registered)
//   tick   out  prescaler enable, high one cycle in every DIV cycles
//   level  out  debounced button level
module toggle_pulse_gen #(
  parameter int DIV       = 50000,
  parameter int DEB_TICKS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic t,
  output logic tick,
  output logic level
);

  localparam int SYNC_STAGES = 2;
  localparam int PW = $clog2(DIV);
  localparam int CW = $clog2(DEB_TICKS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_TICKS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   btn_s;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      assign sync_next[gi] = btn;
    end else begin : g_chain
      assign sync_next[gi] = sync_reg[gi-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign btn_s = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg <= '0;
    end else if (presc_reg == PRESC_LAST) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // Decoded directly from the counter, so it is low while reset holds it at 0.
  assign tick = (presc_reg == PRESC_LAST);

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  state_t        state_reg;
  state_t        state_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] cnt_inc;
  logic          t_reg;
  logic          t_next;

  // Saturating increment. The FSM leaves the wait states on reaching
  // DEB_LAST, so the clamp only guards against a wrap.
  assign cnt_inc = (cnt_reg >= DEB_LAST) ? DEB_LAST : cnt_reg + CNT_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      t_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      t_reg     <= t_next;
    end
  end

  // In both wait states a bounce is tested before the tick. A level change
  // therefore clears the count, even when a tick arrives in the same cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    t_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (btn_s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (tick) begin
          cnt_next = cnt_inc;
          if (cnt_inc == DEB_LAST) begin
            state_next = HELD;
            t_next     = 1'b1;   // the only path that raises the strobe
          end
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (tick) begin
          cnt_next = cnt_inc;
          if (cnt_inc == DEB_LAST) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign t     = t_reg;
  assign level = (state_reg == HELD) || (state_reg == RELEASE_WAIT);

endmodule
